// File: rtl/aes_block_ctrl_pkg.sv
// Shared types for the AES block controller: FSM state encoding and the shadow
// configuration captured on start.
package aes_block_ctrl_pkg;

    localparam int unsigned AES_WORD_BYTES = 4;
    localparam int unsigned AES_NB_W_MAX   = 32;

    typedef enum logic [3:0] {
        IDLE,
        START,
        KEY_REQ,
        KEY_WAIT,
        DATA_REQ,
        DATA_WAIT,
        CRYPT,
        CRYPT_WAIT,
        OUT_REQ,
        OUT_WAIT,
        FINISHED
    } aes_ctrl_state_t;

    typedef struct packed {
        logic [AES_NB_W_MAX-1:0] nblocks;
        logic [3:0]              key_words;
        logic                    decrypt;
    } aes_block_cfg_t;

endpackage

// File: rtl/aes_block_ctrl_if.sv
// Bundle of slave config/flags, source/sink streamer handshakes and AES engine
// controls seen by the block controller.
interface aes_block_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NB_W   = 16,
    parameter int unsigned IDX_W  = 3
);
    logic              start;
    logic [ADDR_W-1:0] cfg_src_addr;
    logic [ADDR_W-1:0] cfg_dst_addr;
    logic [ADDR_W-1:0] cfg_key_addr;
    logic [NB_W-1:0]   cfg_nblocks;
    logic [3:0]        cfg_key_words;
    logic              cfg_decrypt;

    logic              src_req_start;
    logic [ADDR_W-1:0] src_base_addr;
    logic              src_ready_start;
    logic              src_done;

    logic              snk_req_start;
    logic [ADDR_W-1:0] snk_base_addr;
    logic              snk_ready_start;
    logic              snk_done;

    logic              eng_clear;
    logic              eng_load_key;
    logic              eng_load_data;
    logic              eng_unload;
    logic [IDX_W-1:0]  eng_idx;
    logic              eng_go;
    logic              eng_decrypt;
    logic              eng_done;

    logic              busy;
    logic              done;

    modport master (
        input  start, cfg_src_addr, cfg_dst_addr, cfg_key_addr, cfg_nblocks,
               cfg_key_words, cfg_decrypt,
        input  src_ready_start, src_done, snk_ready_start, snk_done, eng_done,
        output src_req_start, src_base_addr, snk_req_start, snk_base_addr,
               eng_clear, eng_load_key, eng_load_data, eng_unload, eng_idx,
               eng_go, eng_decrypt, busy, done
    );

    modport slave (
        output start, cfg_src_addr, cfg_dst_addr, cfg_key_addr, cfg_nblocks,
               cfg_key_words, cfg_decrypt,
        output src_ready_start, src_done, snk_ready_start, snk_done, eng_done,
        input  src_req_start, src_base_addr, snk_req_start, snk_base_addr,
               eng_clear, eng_load_key, eng_load_data, eng_unload, eng_idx,
               eng_go, eng_decrypt, busy, done
    );

endinterface

// File: rtl/aes_block_ctrl_word_addr_gen.sv
// Word pointer plus word counter: load a base, step by a fixed byte stride
// (wrapping at 2^ADDR_W), and clear the counter at phase boundaries.
module aes_block_ctrl_word_addr_gen #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned STRIDE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              step,
    input  logic              cnt_clr,
    output logic [ADDR_W-1:0] ptr,
    output logic [CNT_W-1:0]  cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (clear) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            // a load overrides a simultaneous step (pointer switch on the last key word)
            if (load)
                ptr <= load_addr;
            else if (step)
                ptr <= ptr + ADDR_W'(STRIDE);
            if (cnt_clr)
                cnt <= '0;
            else if (step)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aes_block_ctrl.sv
// Control FSM for the AES HWPE: optional key load, then per block load words,
// trigger the engine and store words through the source/sink streamers.
module aes_block_ctrl
    import aes_block_ctrl_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned KEY_WORDS_MAX   = 8,
    parameter int unsigned WORD_BYTES      = AES_WORD_BYTES,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned NB_W            = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    aes_block_ctrl_if.master bus
);

    localparam int unsigned IDX_W = (KEY_WORDS_MAX > 1) ? $clog2(KEY_WORDS_MAX) : 1;

    aes_ctrl_state_t   state;
    aes_block_cfg_t    cfg_q;
    logic [ADDR_W-1:0] src_addr_q;
    logic [NB_W-1:0]   blk_cnt;

    logic              src_load, src_step, src_clr;
    logic [ADDR_W-1:0] src_load_addr;
    logic              dst_step, dst_clr;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [IDX_W-1:0]  src_cnt, dst_cnt;

    logic [3:0] kw_in;
    logic       key_last, data_last, out_last, blk_last;

    // oversized key counts are clamped so the key phase always terminates
    assign kw_in = (32'(bus.cfg_key_words) > KEY_WORDS_MAX) ? 4'(KEY_WORDS_MAX)
                                                            : bus.cfg_key_words;

    assign key_last  = (32'(src_cnt) + 32'd1 == 32'(cfg_q.key_words));
    assign data_last = (32'(src_cnt) == WORDS_PER_BLOCK - 1);
    assign out_last  = (32'(dst_cnt) == WORDS_PER_BLOCK - 1);
    assign blk_last  = (AES_NB_W_MAX'(blk_cnt) + AES_NB_W_MAX'(1) == cfg_q.nblocks);

    always_comb begin
        src_load      = 1'b0;
        src_load_addr = bus.cfg_src_addr;
        src_step      = 1'b0;
        src_clr       = 1'b0;
        dst_step      = 1'b0;
        dst_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    src_load      = 1'b1;
                    src_load_addr = (kw_in != 4'd0) ? bus.cfg_key_addr : bus.cfg_src_addr;
                    src_clr       = 1'b1;
                    dst_clr       = 1'b1;
                end
            end
            KEY_WAIT: begin
                if (bus.src_done) begin
                    src_step = 1'b1;
                    if (key_last) begin
                        src_load      = 1'b1;
                        src_load_addr = src_addr_q;
                        src_clr       = 1'b1;
                    end
                end
            end
            DATA_WAIT: begin
                if (bus.src_done) begin
                    src_step = 1'b1;
                    src_clr  = data_last;
                end
            end
            OUT_WAIT: begin
                if (bus.snk_done) begin
                    dst_step = 1'b1;
                    dst_clr  = out_last;
                end
            end
            default: ;
        endcase
    end

    // one pointer serves the key then the plaintext; the plaintext base is held aside
    aes_block_ctrl_word_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (IDX_W),
        .STRIDE (WORD_BYTES)
    ) u_src_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .load      (src_load),
        .load_addr (src_load_addr),
        .step      (src_step),
        .cnt_clr   (src_clr),
        .ptr       (src_ptr),
        .cnt       (src_cnt)
    );

    aes_block_ctrl_word_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (IDX_W),
        .STRIDE (WORD_BYTES)
    ) u_dst_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .load      (state == IDLE && bus.start),
        .load_addr (bus.cfg_dst_addr),
        .step      (dst_step),
        .cnt_clr   (dst_clr),
        .ptr       (dst_ptr),
        .cnt       (dst_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cfg_q      <= '0;
            src_addr_q <= '0;
            blk_cnt    <= '0;
        end else if (clear) begin
            state      <= IDLE;
            cfg_q      <= '0;
            src_addr_q <= '0;
            blk_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cfg_q.nblocks   <= AES_NB_W_MAX'(bus.cfg_nblocks);
                        cfg_q.key_words <= kw_in;
                        cfg_q.decrypt   <= bus.cfg_decrypt;
                        src_addr_q      <= bus.cfg_src_addr;
                        blk_cnt         <= '0;
                        state           <= START;
                    end
                end
                START: begin
                    if (cfg_q.nblocks == '0)
                        state <= FINISHED;
                    else if (cfg_q.key_words != 4'd0)
                        state <= KEY_REQ;
                    else
                        state <= DATA_REQ;
                end
                KEY_REQ:   if (bus.src_ready_start) state <= KEY_WAIT;
                KEY_WAIT:  if (bus.src_done) state <= key_last ? DATA_REQ : KEY_REQ;
                DATA_REQ:  if (bus.src_ready_start) state <= DATA_WAIT;
                DATA_WAIT: if (bus.src_done) state <= data_last ? CRYPT : DATA_REQ;
                CRYPT:      state <= CRYPT_WAIT;
                CRYPT_WAIT: if (bus.eng_done) state <= OUT_REQ;
                OUT_REQ:   if (bus.snk_ready_start) state <= OUT_WAIT;
                OUT_WAIT: begin
                    if (bus.snk_done) begin
                        if (out_last) begin
                            blk_cnt <= blk_cnt + NB_W'(1);
                            state   <= blk_last ? FINISHED : DATA_REQ;
                        end else begin
                            state <= OUT_REQ;
                        end
                    end
                end
                FINISHED: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == FINISHED);
    assign bus.eng_clear     = (state == IDLE);
    assign bus.src_req_start = (state == KEY_REQ) || (state == DATA_REQ);
    assign bus.src_base_addr = src_ptr;
    assign bus.snk_req_start = (state == OUT_REQ);
    assign bus.snk_base_addr = dst_ptr;
    assign bus.eng_load_key  = (state == KEY_WAIT) && bus.src_done;
    assign bus.eng_load_data = (state == DATA_WAIT) && bus.src_done;
    assign bus.eng_unload    = (state == OUT_WAIT) && bus.snk_done;
    assign bus.eng_idx       = (state == OUT_REQ || state == OUT_WAIT) ? dst_cnt : src_cnt;
    assign bus.eng_go        = (state == CRYPT);
    assign bus.eng_decrypt   = cfg_q.decrypt;

endmodule
